// File: rtl/abqm_pkg.sv
// Shared definitions for the teller dispatch controller.
// Holds the FSM encoding, the parameter defaults and the queue-occupancy width.
package abqm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int N_TELLERS_DEF   = 3;
  localparam int TICKET_W_DEF    = 4;
  localparam int SVC_TIMEOUT_DEF = 15;
  localparam int PCOUNT_W        = 3;

  // A one-entry index still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/teller_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr, wrapping.
// Returns a one-hot grant, its index, and whether any request was present.
module rr_arbiter
  import abqm_pkg::*;
#(
  parameter int N     = N_TELLERS_DEF,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W-1:0] idx_v;

  always_comb begin
    gnt     = '0;
    valid   = 1'b0;
    gnt_idx = '0;
    idx_v   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_v = PTR_W'((int'(ptr) + k) % N);
      if (!valid && req[idx_v]) begin
        valid        = 1'b1;
        gnt[idx_v]   = 1'b1;
        gnt_idx      = idx_v;
      end
    end
  end

endmodule

// File: rtl/teller_dispatcher.sv
// Shares enabled tellers among waiting customers: round-robin grant, one-clk pop to the
// queue counter, ticket issue and per-teller service timeout.
module teller_dispatcher
  import abqm_pkg::*;
#(
  parameter int N_TELLERS   = N_TELLERS_DEF,
  parameter int TICKET_W    = TICKET_W_DEF,
  parameter int SVC_TIMEOUT = SVC_TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic [1:0]                      tcount,
  input  logic [PCOUNT_W-1:0]             pcount,
  input  logic                            in,
  input  logic [N_TELLERS-1:0]            teller_done,
  output logic                            out,
  output logic [N_TELLERS-1:0]            grant,
  output logic [N_TELLERS-1:0]            busy,
  output logic [N_TELLERS*TICKET_W-1:0]   teller_ticket,
  output logic [N_TELLERS-1:0]            timeout
);

  localparam int PTR_W = ptr_width(N_TELLERS);
  localparam int TMR_W = $clog2(SVC_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N_TELLERS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SVC_TIMEOUT - 1);

  state_t                          state_q, state_d;
  logic                            out_q, out_d;
  logic [N_TELLERS-1:0]            grant_q, grant_d;
  logic [N_TELLERS-1:0]            busy_q, busy_d;
  logic [N_TELLERS-1:0]            timeout_q, timeout_d;
  logic [N_TELLERS*TICKET_W-1:0]   ticket_q, ticket_d;
  logic [TICKET_W-1:0]             ctr_q, ctr_d;
  logic [PTR_W-1:0]                rr_q, rr_d;
  logic [N_TELLERS-1:0][TMR_W-1:0] tmr_q, tmr_d;

  logic [N_TELLERS-1:0]            eligible;
  logic [N_TELLERS-1:0]            arb_gnt;
  logic                            arb_valid;
  logic [PTR_W-1:0]                arb_idx;
  logic                            start_grant;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      eligible[i] = (i < int'(tcount)) && !busy_q[i];
    end
  end

  rr_arbiter #(
    .N     (N_TELLERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (eligible),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .valid   (arb_valid),
    .gnt_idx (arb_idx)
  );

  // A pop coinciding with `in` would be lost at the counter, so the grant waits for in==0.
  always_comb begin
    state_d     = state_q;
    start_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pcount != '0) && arb_valid && !in) begin
          state_d     = GRANT;
          start_grant = 1'b1;
        end
      end
      GRANT:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake: out is a one-clk pop with no back-pressure; grant is one-hot in that same cycle.
  always_comb begin
    out_d     = start_grant;
    grant_d   = start_grant ? arb_gnt : '0;
    busy_d    = busy_q;
    timeout_d = '0;
    tmr_d     = tmr_q;
    ticket_d  = ticket_q;
    ctr_d     = ctr_q;
    rr_d      = rr_q;

    for (int i = 0; i < N_TELLERS; i++) begin
      if (busy_q[i]) begin
        if (teller_done[i]) begin
          busy_d[i] = 1'b0;
        end else if (tick) begin
          tmr_d[i] = tmr_q[i] + TMR_W'(1);
          if (tmr_q[i] == TMR_LAST) begin
            busy_d[i]    = 1'b0;
            timeout_d[i] = 1'b1;
          end
        end
      end
    end

    // The granted teller is idle, so this never collides with its own release above.
    if (start_grant) begin
      busy_d[arb_idx]                           = 1'b1;
      tmr_d[arb_idx]                            = '0;
      ticket_d[int'(arb_idx)*TICKET_W +: TICKET_W] = ctr_q;
      ctr_d                                     = ctr_q + TICKET_W'(1);
      rr_d                                      = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_q     <= 1'b0;
      grant_q   <= '0;
      busy_q    <= '0;
      timeout_q <= '0;
      ticket_q  <= '0;
      ctr_q     <= '0;
      rr_q      <= PTR_RST;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ticket_q  <= ticket_d;
      ctr_q     <= ctr_d;
      rr_q      <= rr_d;
      tmr_q     <= tmr_d;
    end
  end

  assign out           = out_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign teller_ticket = ticket_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Bench for teller_dispatcher: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the dispatch rules.
module tb_teller_dispatcher;

  localparam int N   = 3;
  localparam int TW  = 4;
  localparam int SVC = 15;
  localparam int IW  = 2;
  localparam int EW  = IW + N + TW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    tcount = '0;
  logic [2:0]    pcount = '0;
  logic          in = 1'b0;
  logic [N-1:0]  teller_done = '0;
  logic          out;
  logic [N-1:0]  grant;
  logic [N-1:0]  busy;
  logic [N*TW-1:0] teller_ticket;
  logic [N-1:0]  timeout;

  always #5 clk = ~clk;

  teller_dispatcher #(
    .N_TELLERS   (N),
    .TICKET_W    (TW),
    .SVC_TIMEOUT (SVC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .tcount        (tcount),
    .pcount        (pcount),
    .in            (in),
    .teller_done   (teller_done),
    .out           (out),
    .grant         (grant),
    .busy          (busy),
    .teller_ticket (teller_ticket),
    .timeout       (timeout)
  );

  // Scoreboard queues: expected pops {index, one-hot, ticket} and expected timeout masks.
  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  to_q[$];

  bit m_busy[N];
  int m_timer[N];
  int m_rr, m_ticket, m_last_pop, cyc;
  int tests, fails;
  bit mon_en = 1'b0;

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    m_rr = N - 1;
    m_ticket = 0;
    m_last_pop = -100;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_timer[i] = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pop needs a waiting customer, an enabled free teller, no arrival
  // strobe and at least 3 clocks since the previous pop.
  always @(posedge clk) begin : ref_model
    int g;
    int idx;
    logic [N-1:0] tmask;
    logic [N-1:0] oh;
    cyc = cyc + 1;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_timer[i] = 0;
      end
      m_rr = N - 1;
      m_ticket = 0;
      m_last_pop = -100;
    end else begin
      g = -1;
      if ((cyc - m_last_pop) >= 3 && pcount != 0 && !in) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && idx < int'(tcount) && !m_busy[idx]) g = idx;
        end
      end
      tmask = '0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          if (teller_done[i]) begin
            m_busy[i] = 1'b0;
          end else if (tick) begin
            m_timer[i] = m_timer[i] + 1;
            if (m_timer[i] == SVC) begin
              m_busy[i] = 1'b0;
              tmask[i] = 1'b1;
            end
          end
        end
      end
      if (tmask != '0) to_q.push_back(tmask);
      if (g >= 0) begin
        oh = '0;
        oh[g] = 1'b1;
        exp_q.push_back({IW'(g), oh, TW'(m_ticket)});
        m_busy[g] = 1'b1;
        m_timer[g] = 0;
        m_ticket = (m_ticket + 1) % (1 << TW);
        m_rr = g;
        m_last_pop = cyc;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic [N-1:0] mb;
    logic [N-1:0] et;
    int ei;
    if (mon_en) begin
      for (int i = 0; i < N; i++) mb[i] = m_busy[i];
      check("busy", 32'(busy), 32'(mb));
      if (out || exp_q.size() != 0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: out=%b grant=%b, expected no pop (t=%0t)", out, grant, $time);
        end else begin
          e = exp_q.pop_front();
          ei = int'(e[EW-1 -: IW]);
          check("pop_out", 32'(out), 32'd1);
          check("pop_grant", 32'(grant), 32'(e[TW +: N]));
          check("pop_ticket", 32'(teller_ticket[ei*TW +: TW]), 32'(e[TW-1:0]));
        end
      end else begin
        check("grant_idle", 32'(grant), 32'd0);
      end
      if (timeout != '0 || to_q.size() != 0) begin
        if (to_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL timeout_unexpected: timeout=%b, expected 0 (t=%0t)", timeout, $time);
        end else begin
          et = to_q.pop_front();
          check("timeout_mask", 32'(timeout), 32'(et));
        end
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_n(1);
    reset = 1'b1;
  endtask

  task automatic pulse_done(input logic [N-1:0] m);
    teller_done = m;
    clk_n(1);
    teller_done = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(1);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int npop;
    int gi;
    // Reset held for two edges with customers waiting.
    reset = 1'b0;
    pcount = 3'd5;
    tcount = 2'd3;
    @(posedge clk);
    #1;
    clk_n(1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_ticket", 32'(teller_ticket), 32'd0);
    mon_en = 1'b1;

    // Round-robin from reset: 001, 010, 100 three clocks apart, tickets 0,1,2.
    reset = 1'b1;
    pcount = 3'd3;
    clk_n(1);
    check("rr0_grant", 32'(grant), 32'b001);
    check("rr0_ticket", 32'(teller_ticket[3:0]), 32'd0);
    clk_n(3);
    check("rr1_grant", 32'(grant), 32'b010);
    check("rr1_ticket", 32'(teller_ticket[7:4]), 32'd1);
    clk_n(3);
    check("rr2_grant", 32'(grant), 32'b100);
    check("rr2_ticket", 32'(teller_ticket[11:8]), 32'd2);
    pcount = 3'd0;
    clk_n(4);
    pulse_done(3'b111);
    clk_n(3);

    // Arrival strobe blocks the pop; it fires one clock after in drops.
    pcount = 3'd2;
    in = 1'b1;
    repeat (4) begin
      clk_n(1);
      check("in_guard_out", 32'(out), 32'd0);
    end
    in = 1'b0;
    clk_n(1);
    check("in_release_out", 32'(out), 32'd1);
    pcount = 3'd0;
    clk_n(4);
    pulse_done(3'b111);
    clk_n(2);

    // Capacity: a single enabled teller serves one customer at a time.
    do_reset();
    tcount = 2'd1;
    pcount = 3'd4;
    clk_n(10);
    check("cap_busy", 32'(busy), 32'b001);
    pulse_done(3'b001);
    for (int c = 0; c < 8; c++) begin
      clk_n(1);
      if (out) break;
    end
    check("cap_regrant_out", 32'(out), 32'd1);
    check("cap_regrant_grant", 32'(grant), 32'b001);
    check("cap_regrant_ticket", 32'(teller_ticket[3:0]), 32'd1);
    pcount = 3'd0;
    clk_n(3);
    pulse_done(3'b001);
    clk_n(2);

    // Timeout on teller 1 after 15 ticks.
    do_reset();
    tcount = 2'd2;
    pcount = 3'd1;
    clk_n(5);
    pcount = 3'd0;
    pulse_done(3'b001);
    ticks(14);
    tick = 1'b1;
    clk_n(1);
    tick = 1'b0;
    check("to_pulse", 32'(timeout), 32'b010);
    check("to_busy1", 32'(busy[1]), 32'd0);
    clk_n(1);
    check("to_one_clk", 32'(timeout), 32'd0);

    // Done on the 15th tick wins over the timeout.
    pcount = 3'd1;
    clk_n(5);
    pcount = 3'd0;
    pulse_done(3'b001);
    ticks(14);
    tick = 1'b1;
    teller_done = 3'b010;
    clk_n(1);
    tick = 1'b0;
    teller_done = '0;
    check("done_wins_timeout", 32'(timeout), 32'd0);
    check("done_wins_busy", 32'(busy), 32'd0);
    clk_n(1);
    check("done_wins_later", 32'(timeout), 32'd0);

    // Ticket wrap: 17th serve after reset carries ticket 0.
    do_reset();
    tcount = 2'd3;
    pcount = 3'd1;
    teller_done = 3'b111;
    npop = 0;
    for (int c = 0; c < 60; c++) begin
      clk_n(1);
      if (out) begin
        npop++;
        if (npop == 17) begin
          gi = 0;
          for (int i = 0; i < N; i++) if (grant[i]) gi = i;
          check("wrap_ticket", 32'(teller_ticket[gi*TW +: TW]), 32'd0);
        end
      end
    end
    check("wrap_enough_pops", 32'(npop >= 17), 32'd1);

    // Empty queue: no pop at all.
    pcount = 3'd0;
    clk_n(3);
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      clk_n(1);
      if (out) npop++;
    end
    check("empty_no_pop", 32'(npop), 32'd0);
    teller_done = '0;

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 399) != 0);
      tcount = 2'($urandom_range(0, 3));
      pcount = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      in = ($urandom_range(0, 3) == 0);
      tick = ($urandom_range(0, 2) == 0);
      teller_done = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 7)) : '0;
      clk_n(1);
    end
    reset = 1'b1;
    in = 1'b0;
    tick = 1'b0;
    pcount = 3'd0;
    teller_done = 3'b111;
    clk_n(6);
    teller_done = '0;
    clk_n(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("to_q_drained", 32'(to_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
